imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'hF000_0000: overflow-exception handler address.
REQ-003 Parameter RD_CYCLES, default 1, legal range 1..15: CLK cycles the instruction memory needs per read (T_rd=20ns).
REQ-004 Parameter BUF_DEPTH, default 2, power of two: prefetch buffer entries.
REQ-005 Port CLK, input, 1: single clock; all state on rising edge.
REQ-006 Port Reset_L, input, 1: reset, asynchronous, active-low.
REQ-007 Port Address, output, 32: instruction memory address.
REQ-008 Port Data, input, 32: instruction memory read data, combinational from Address.
REQ-009 Port RedirectValid, input, 1: branch/jump/jr redirect strobe.
REQ-010 Port RedirectPC, input, 32: redirect target.
REQ-011 Port ExcValid, input, 1: overflow exception strobe.
REQ-012 Port Instr, output, 32: head-of-buffer instruction.
REQ-013 Port InstrPC, output, 32: address of Instr.
REQ-014 Port InstrValid, output, 1: Instr/InstrPC valid.
REQ-015 Port InstrReady, input, 1: pipeline accepts Instr; transfer when InstrValid and InstrReady high on same edge.

Function
REQ-016 States FETCH and HOLD; FETCH drives fetch PC onto Address and runs wait counter rd_cnt from 0 to RD_CYCLES-1.
REQ-017 In FETCH, edge with rd_cnt==RD_CYCLES-1 and buffer not full (or full with pop same edge): push {Data, PC}, PC<=PC+4, rd_cnt<=0, stay FETCH.
REQ-018 In FETCH, capture edge with buffer full and no pop: no push, go HOLD, PC and Address unchanged.
REQ-019 In HOLD: Address held; on pop, go FETCH with rd_cnt<=0 (full re-read).
REQ-020 Address is always PC with bits [1:0] forced 0; PC+4 wraps 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 ExcValid: same edge flush buffer, PC<=EXC_VECTOR, rd_cnt<=0, state FETCH; any push/pop on that edge is discarded.
REQ-022 RedirectValid without ExcValid: as REQ-021 with PC<=RedirectPC & ~32'h3.
REQ-023 ExcValid and RedirectValid together: exception wins, redirect ignored.
REQ-024 Buffer FIFO order; simultaneous push and pop when full allowed; when empty, push is visible on InstrValid the next cycle (no bypass).
REQ-025 Instr, InstrPC, InstrValid driven only from buffer registers; InstrValid=0 whenever buffer empty.
REQ-026 Fetch latency: first InstrValid RD_CYCLES cycles after reset release or flush edge.

Reset
REQ-027 Reset_L low asynchronously: PC=RESET_PC, Address=RESET_PC, rd_cnt=0, state FETCH, buffer empty, InstrValid=0, Instr=0, InstrPC=0.
REQ-028 Reset asserted mid-read or mid-HOLD discards all in-flight and buffered instructions; no partial push.
REQ-029 Operation resumes on first rising CLK edge after Reset_L deasserts.

Structure
REQ-030 Shared package mips_fetch_pkg holds state encoding, default RESET_PC and EXC_VECTOR constants, and fetch-entry width (64 bits: instr+PC).
REQ-031 Buffer implemented as sub-module fetch_fifo (push/pop/flush, full/empty, async active-low reset); control FSM and PC in top.

Verification
REQ-032 Reset, RD_CYCLES=1, InstrReady=1 -> Address 0x00,0x04,0x08; outputs (0x00,0x34080032),(0x04,0xac080000),(0x08,0x34080028) on consecutive cycles.
REQ-033 InstrReady=0 from reset -> exactly 2 entries (PC 0x00,0x04), Address holds 0x08 in HOLD; InstrReady=1 -> 0x08 delivered after re-read, no duplicate or loss.
REQ-034 RedirectValid, RedirectPC=0x182 while buffer holds 2 -> buffer flushed, next output (0x180,0x3409feed) then (0x184,0x34080190).
REQ-035 ExcValid and RedirectValid=0x500 same edge -> next output (0xF0000000,0x8c080000); no 0x500 fetch.
REQ-036 RD_CYCLES=3 -> Address stable 3 cycles per fetch; Reset_L pulsed low at cycle 2 of a read -> InstrValid=0 immediately, refetch from 0x00.
REQ-037 RedirectPC=0xFFFFFFFC -> following fetch Address 0x00000000.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch front end:
//            FSM state encoding, default reset/exception addresses and the
//            prefetch buffer entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

  // Fetch FSM: FETCH reads memory, HOLD parks while the buffer is full
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'hF000_0000;

  // One buffer entry: instruction word plus the address it came from
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Word-align an address; fetch addresses never carry byte-offset bits
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl_if
// Purpose  : Bundles the instruction-memory bus, redirect/exception strobes
//            and the instruction handshake toward the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;
  logic [31:0] Address;
  logic [31:0] Data;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        ExcValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;

  // Fetch controller side
  modport master (
    output Address,
    input  Data,
    input  RedirectValid,
    input  RedirectPC,
    input  ExcValid,
    output Instr,
    output InstrPC,
    output InstrValid,
    input  InstrReady
  );

  // Memory / pipeline side
  modport slave (
    input  Address,
    output Data,
    output RedirectValid,
    output RedirectPC,
    output ExcValid,
    input  Instr,
    input  InstrPC,
    input  InstrValid,
    output InstrReady
  );
endinterface : imem_fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Prefetch buffer. Head entry is read straight from storage
//            registers (no bypass), so a push shows up one cycle later.
//            Flush empties the buffer and overrides any push/pop that edge.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire logic         flush_i,
  input  wire fetch_entry_t wdata_i,
  output fetch_entry_t      rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full buffer is legal only when the head leaves the same edge
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == C_LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == C_LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers; reset clears entries so the head reads zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch controller. Walks the PC through a
//            multi-cycle instruction memory, fills a prefetch buffer and
//            handles redirects and overflow exceptions by flushing.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter int          RD_CYCLES  = 1,
  parameter int          BUF_DEPTH  = 2
) (
  input  wire logic          CLK,
  input  wire logic          Reset_L,
  imem_fetch_ctrl_if.master  bus
);

  localparam logic [3:0] C_RD_LAST = 4'(RD_CYCLES - 1);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [3:0]   rd_cnt_q;

  logic         flush, pop, capture, push;
  logic         buf_full, buf_empty;
  fetch_entry_t push_entry, head_entry;

  // pc_q is only ever loaded with aligned values, so it drives Address directly
  assign bus.Address = pc_q;

  assign flush   = bus.ExcValid | bus.RedirectValid;
  assign pop     = !buf_empty && bus.InstrReady;
  assign capture = (state_q == ST_FETCH) && (rd_cnt_q == C_RD_LAST);
  assign push    = capture && (!buf_full || pop) && !flush;

  assign push_entry = '{instr: bus.Data, pc: pc_q};

  assign bus.Instr      = head_entry.instr;
  assign bus.InstrPC    = head_entry.pc;
  assign bus.InstrValid = !buf_empty;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (Reset_L),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // Fetch FSM: PC, read wait counter and FETCH/HOLD state; exception beats redirect
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= ST_FETCH;
      pc_q     <= align_pc(RESET_PC);
      rd_cnt_q <= '0;
    end else if (bus.ExcValid) begin
      state_q  <= ST_FETCH;
      pc_q     <= align_pc(EXC_VECTOR);
      rd_cnt_q <= '0;
    end else if (bus.RedirectValid) begin
      state_q  <= ST_FETCH;
      pc_q     <= align_pc(bus.RedirectPC);
      rd_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (capture) begin
            if (push) begin
              pc_q     <= pc_q + 32'd4;
              rd_cnt_q <= '0;
            end else begin
              // Buffer full with nothing leaving: park on this address
              state_q <= ST_HOLD;
            end
          end else begin
            rd_cnt_q <= rd_cnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          // Memory read data is not kept, so the word is re-read in full
          if (pop) begin
            state_q  <= ST_FETCH;
            rd_cnt_q <= '0;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule : imem_fetch_ctrl
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl: directed vector table,
//            a reset-during-read sequence on a slow memory, and random
//            traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  logic CLK = 1'b0;
  logic rst1_n, rst3_n;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  // Instruction memory image; unlisted words get a distinct address-derived value
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3408_0032;
      32'h0000_0004: return 32'hac08_0000;
      32'h0000_0008: return 32'h3408_0028;
      32'h0000_0180: return 32'h3409_feed;
      32'h0000_0184: return 32'h3408_0190;
      32'hF000_0000: return 32'h8c08_0000;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  imem_fetch_ctrl_if if1 ();
  imem_fetch_ctrl_if if3 ();

  assign if1.Data = mem_word(if1.Address);
  assign if3.Data = mem_word(if3.Address);

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000), .EXC_VECTOR (32'hF000_0000),
    .RD_CYCLES (1), .BUF_DEPTH (2)
  ) u_dut1 (.CLK (CLK), .Reset_L (rst1_n), .bus (if1));

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000), .EXC_VECTOR (32'hF000_0000),
    .RD_CYCLES (3), .BUF_DEPTH (2)
  ) u_dut3 (.CLK (CLK), .Reset_L (rst3_n), .bus (if3));

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic rst_n, input logic ready, input logic rv,
                              input logic [31:0] rpc, input logic exc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ei,
                              input logic [31:0] ea);
    vec_t v;
    v.rst_n = rst_n; v.ready = ready; v.rv = rv; v.rpc = rpc; v.exc = exc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ei; v.exp_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic set_in(input int which, input logic rst_n, input logic ready,
                        input logic rv, input logic [31:0] rpc, input logic exc);
    if (which == 0) begin
      rst1_n = rst_n; if1.InstrReady = ready; if1.RedirectValid = rv;
      if1.RedirectPC = rpc; if1.ExcValid = exc;
    end else begin
      rst3_n = rst_n; if3.InstrReady = ready; if3.RedirectValid = rv;
      if3.RedirectPC = rpc; if3.ExcValid = exc;
    end
  endtask

  task automatic get_out(input int which, output logic v, output logic [31:0] pc,
                         output logic [31:0] ins, output logic [31:0] addr);
    if (which == 0) begin
      v = if1.InstrValid; pc = if1.InstrPC; ins = if1.Instr; addr = if1.Address;
    end else begin
      v = if3.InstrValid; pc = if3.InstrPC; ins = if3.Instr; addr = if3.Address;
    end
  endtask

  // Random traffic against a model of the fetch rules built on a queue
  task automatic run_random(input int which, input int rd, input int n);
    logic [63:0] q[$];
    logic [31:0] pc, rpc, a_pc, a_ins, a_addr;
    int          cnt;
    bit          hold, pop;
    logic        ready, rv, exc, a_v;
    set_in(which, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge CLK); #1;
    get_out(which, a_v, a_pc, a_ins, a_addr);
    chk("rnd_reset_valid", which, {31'b0, a_v}, 32'h0);
    q.delete(); pc = 32'h0; cnt = 0; hold = 0;
    for (int c = 0; c < n; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 19) == 0);
      exc   = ($urandom_range(0, 39) == 0);
      rpc   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : $urandom;
      set_in(which, 1'b1, ready, rv, rpc, exc);
      pop = (q.size() > 0) && ready;
      if (exc) begin
        q.delete(); pc = 32'hF000_0000; cnt = 0; hold = 0;
      end else if (rv) begin
        q.delete(); pc = rpc & ~32'h3; cnt = 0; hold = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (hold) begin
          if (pop) begin hold = 0; cnt = 0; end
        end else if (cnt == rd - 1) begin
          if (q.size() < 2) begin
            q.push_back({mem_word(pc), pc});
            pc = pc + 32'd4;
            cnt = 0;
          end else begin
            hold = 1;
          end
        end else begin
          cnt++;
        end
      end
      @(posedge CLK); #1;
      get_out(which, a_v, a_pc, a_ins, a_addr);
      chk("rnd_valid", c, {31'b0, a_v}, {31'b0, q.size() > 0});
      chk("rnd_addr", c, a_addr, pc);
      if (q.size() > 0) begin
        chk("rnd_pc", c, a_pc, q[0][31:0]);
        chk("rnd_instr", c, a_ins, q[0][63:32]);
      end
    end
  endtask

  initial begin
    logic        v;
    logic [31:0] pc, ins, addr;

    set_in(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    //           rst ry rv rpc            ex  valid pc            instr          addr
    vt[0]  = mk(0, 0, 0, 32'h0,          0,  0, 32'h0,         32'h0,         32'h0);
    vt[1]  = mk(1, 1, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h4);
    vt[2]  = mk(1, 1, 0, 32'h0,          0,  1, 32'h4,         32'hac08_0000, 32'h8);
    vt[3]  = mk(1, 1, 0, 32'h0,          0,  1, 32'h8,         32'h3408_0028, 32'hC);
    vt[4]  = mk(0, 0, 0, 32'h0,          0,  0, 32'h0,         32'h0,         32'h0);
    vt[5]  = mk(1, 0, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h4);
    vt[6]  = mk(1, 0, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h8);
    vt[7]  = mk(1, 0, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h8);
    vt[8]  = mk(1, 0, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h8);
    vt[9]  = mk(1, 1, 0, 32'h0,          0,  1, 32'h4,         32'hac08_0000, 32'h8);
    vt[10] = mk(1, 1, 0, 32'h0,          0,  1, 32'h8,         32'h3408_0028, 32'hC);
    vt[11] = mk(1, 0, 0, 32'h0,          0,  1, 32'h8,         32'h3408_0028, 32'h10);
    vt[12] = mk(1, 0, 1, 32'h182,        0,  0, 32'h0,         32'h0,         32'h180);
    vt[13] = mk(1, 1, 0, 32'h0,          0,  1, 32'h180,       32'h3409_feed, 32'h184);
    vt[14] = mk(1, 1, 0, 32'h0,          0,  1, 32'h184,       32'h3408_0190, 32'h188);
    vt[15] = mk(1, 1, 1, 32'h500,        1,  0, 32'h0,         32'h0,         32'hF000_0000);
    vt[16] = mk(1, 1, 0, 32'h0,          0,  1, 32'hF000_0000, 32'h8c08_0000, 32'hF000_0004);
    vt[17] = mk(1, 1, 1, 32'hFFFF_FFFC,  0,  0, 32'h0,         32'h0,         32'hFFFF_FFFC);
    vt[18] = mk(1, 1, 0, 32'h0,          0,  1, 32'hFFFF_FFFC, 32'hA5A5_A5A6, 32'h0);
    vt[19] = mk(1, 1, 0, 32'h0,          0,  1, 32'h0,         32'h3408_0032, 32'h4);

    for (int i = 0; i < 20; i++) begin
      set_in(0, vt[i].rst_n, vt[i].ready, vt[i].rv, vt[i].rpc, vt[i].exc);
      @(posedge CLK); #1;
      get_out(0, v, pc, ins, addr);
      chk("vec_valid", i, {31'b0, v}, {31'b0, vt[i].exp_valid});
      chk("vec_addr", i, addr, vt[i].exp_addr);
      if (vt[i].exp_valid || !vt[i].rst_n) begin
        chk("vec_pc", i, pc, vt[i].exp_pc);
        chk("vec_instr", i, ins, vt[i].exp_instr);
      end
    end

    // Slow memory: address held for three cycles, then reset mid-read
    set_in(1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge CLK); #1;
      get_out(1, v, pc, ins, addr);
      chk("rd3_wait_valid", k, {31'b0, v}, 32'h0);
      chk("rd3_wait_addr", k, addr, 32'h0);
    end
    @(posedge CLK); #1;
    get_out(1, v, pc, ins, addr);
    chk("rd3_first_valid", 0, {31'b0, v}, 32'h1);
    chk("rd3_first_pc", 0, pc, 32'h0);
    chk("rd3_first_instr", 0, ins, 32'h3408_0032);
    chk("rd3_first_addr", 0, addr, 32'h4);
    @(posedge CLK); #1;
    get_out(1, v, pc, ins, addr);
    chk("rd3_mid_valid", 0, {31'b0, v}, 32'h1);
    chk("rd3_mid_addr", 0, addr, 32'h4);
    rst3_n = 1'b0;
    #1;
    get_out(1, v, pc, ins, addr);
    chk("rd3_rst_valid", 0, {31'b0, v}, 32'h0);
    chk("rd3_rst_addr", 0, addr, 32'h0);
    chk("rd3_rst_instr", 0, ins, 32'h0);
    chk("rd3_rst_pc", 0, pc, 32'h0);
    #1 rst3_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge CLK); #1;
      get_out(1, v, pc, ins, addr);
      chk("rd3_re_wait_valid", k, {31'b0, v}, 32'h0);
      chk("rd3_re_wait_addr", k, addr, 32'h0);
    end
    @(posedge CLK); #1;
    get_out(1, v, pc, ins, addr);
    chk("rd3_refetch_valid", 0, {31'b0, v}, 32'h1);
    chk("rd3_refetch_pc", 0, pc, 32'h0);
    chk("rd3_refetch_instr", 0, ins, 32'h3408_0032);

    run_random(0, 1, 400);
    run_random(1, 3, 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_imem_fetch_ctrl
`default_nettype wire
